// File: rtl/updown_counter.sv
// updown_counter: parametrised up/down counter with prescaler,
// wrap/saturate limit mode, clamped load and terminal-count pulse.
module updown_counter #(
  parameter int          WIDTH    = 4,
  parameter int unsigned MAX      = 15,
  parameter int          PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tc
);

  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PW-1:0] PC_LAST =
    PW'(PRESCALE - 1);

  localparam logic [WIDTH-1:0] MAXV =
    WIDTH'(MAX);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_w
    $error("updown_counter: WIDTH out of range");
  end

  if (MAX < 1) begin : g_bad_max
    $error("updown_counter: MAX must be >= 1");
  end

  if (WIDTH < 32) begin : g_chk_max
    if (MAX > (32'd1 << WIDTH) - 32'd1) begin : g_big
      $error("updown_counter: MAX exceeds WIDTH");
    end
  end

  if (PRESCALE < 1) begin : g_bad_pre
    $error("updown_counter: PRESCALE must be >= 1");
  end

  logic [PW-1:0]    pc_q, pc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;

  logic             pc_wrap;
  logic             at_lim;
  logic [WIDTH-1:0] ld_clamp;
  logic [WIDTH-1:0] wrap_val;

  assign pc_wrap  = (pc_q == PC_LAST);
  assign at_lim   = up ? (q_q == MAXV)
                       : (q_q == '0);
  assign ld_clamp = (load_val > MAXV) ? MAXV
                                      : load_val;
  assign wrap_val = up ? '0 : MAXV;

  // next-state: load beats enable; steps are range checked
  always_comb begin
    q_d  = q_q;
    pc_d = pc_q;
    tc_d = 1'b0;
    if (load) begin
      q_d  = ld_clamp;
      pc_d = '0;
    end else if (en) begin
      if (!pc_wrap) begin
        pc_d = pc_q + 1'b1;
      end else begin
        pc_d = '0;
        if (at_lim) begin
          tc_d = 1'b1;
          if (!sat) begin
            q_d = wrap_val;
          end
        end else if (up) begin
          q_d = q_q + 1'b1;
        end else begin
          q_d = q_q - 1'b1;
        end
      end
    end
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q  <= '0;
      pc_q <= '0;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      pc_q <= pc_d;
      tc_q <= tc_d;
    end
  end

  assign Q  = q_q;
  assign tc = tc_q;

endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter: four counter configurations on one
// shared stimulus bus, checked against an arithmetic model.
module tb_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up, sat, load;
  logic [7:0] lv;

  logic [3:0] q0, q1, q2;
  logic [7:0] q3;
  logic       t0, t1, t2, t3;

  logic [7:0] qv [4];
  logic       tcv[4];

  int n_assert = 0;
  int n_fail   = 0;
  bit started  = 0;

  localparam int MX [4] = '{15, 9, 15, 99};
  localparam int PR [4] = '{1, 1, 4, 1};
  localparam int MSK[4] = '{15, 15, 15, 255};

  int mq [4];
  int mpc[4];
  bit mtc[4];

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(4), .MAX(15), .PRESCALE(1)) u0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat),
    .load(load), .load_val(lv[3:0]), .Q(q0), .tc(t0));

  updown_counter #(.WIDTH(4), .MAX(9), .PRESCALE(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat),
    .load(load), .load_val(lv[3:0]), .Q(q1), .tc(t1));

  updown_counter #(.WIDTH(4), .MAX(15), .PRESCALE(4)) u2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat),
    .load(load), .load_val(lv[3:0]), .Q(q2), .tc(t2));

  updown_counter #(.WIDTH(8), .MAX(99), .PRESCALE(1)) u3 (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat),
    .load(load), .load_val(lv), .Q(q3), .tc(t3));

  assign qv[0]  = {4'b0, q0};
  assign qv[1]  = {4'b0, q1};
  assign qv[2]  = {4'b0, q2};
  assign qv[3]  = q3;
  assign tcv[0] = t0;
  assign tcv[1] = t1;
  assign tcv[2] = t2;
  assign tcv[3] = t3;

  task automatic check(input string nm,
                       input int got, input int exp);
    n_assert++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, got, exp);
    end
  endtask

  function automatic void nxt(
    input int mx, input int pr, input int msk,
    input int q, input int pc,
    input bit e, input bit u, input bit s,
    input bit l, input int lval,
    output int nq, output int npc, output bit ntc);
    int lm;
    nq  = q;
    npc = pc;
    ntc = 1'b0;
    lm  = lval & msk;
    if (l) begin
      nq  = (lm > mx) ? mx : lm;
      npc = 0;
    end else if (e) begin
      if (pc + 1 < pr) begin
        npc = pc + 1;
      end else begin
        npc = 0;
        if (u) begin
          if (q == mx) begin
            ntc = 1'b1;
            nq  = s ? mx : 0;
          end else begin
            nq = q + 1;
          end
        end else begin
          if (q == 0) begin
            ntc = 1'b1;
            nq  = s ? 0 : mx;
          end else begin
            nq = q - 1;
          end
        end
      end
    end
  endfunction

  // reference model: one arithmetic update per edge
  always @(posedge clk or negedge rst) begin
    int nq, npc;
    bit ntc;
    for (int i = 0; i < 4; i++) begin
      if (!rst) begin
        mq[i]  <= 0;
        mpc[i] <= 0;
        mtc[i] <= 1'b0;
      end else begin
        nxt(MX[i], PR[i], MSK[i], mq[i], mpc[i],
            en, up, sat, load, int'(lv),
            nq, npc, ntc);
        mq[i]  <= nq;
        mpc[i] <= npc;
        mtc[i] <= ntc;
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("u%0d.Q", i),
              int'(qv[i]), mq[i]);
        check($sformatf("u%0d.tc", i),
              int'(tcv[i]), int'(mtc[i]));
      end
    end
  end

  task automatic pin(input int i, input int eq,
                     input bit et, input string tag);
    check($sformatf("%s u%0d.Q", tag, i),
          int'(qv[i]), eq);
    check($sformatf("%s u%0d.tc", tag, i),
          int'(tcv[i]), int'(et));
    check($sformatf("%s model%0d.Q", tag, i),
          mq[i], eq);
    check($sformatf("%s model%0d.tc", tag, i),
          int'(mtc[i]), int'(et));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst  = 1'b0;
    en   = 1'b0;
    up   = 1'b0;
    sat  = 1'b0;
    load = 1'b0;
    lv   = 8'd0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) pin(i, 0, 0, "reset");
    started = 1;

    // down-count wrap, PRESCALE=1, MAX=15
    rst = 1'b1;
    en  = 1'b1;
    tick();
    pin(0, 15, 1, "down_wrap");
    for (int k = 2; k <= 17; k++) begin
      tick();
      pin(0, (k == 17) ? 15 : 16 - k, k == 17,
          "down_seq");
    end

    // load 7 then up-count wrap at MAX=9
    load = 1'b1;
    lv   = 8'd7;
    up   = 1'b1;
    tick();
    pin(1, 7, 0, "load7");
    load = 1'b0;
    tick();
    pin(1, 8, 0, "up8");
    tick();
    pin(1, 9, 0, "up9");
    tick();
    pin(1, 0, 1, "up_wrap");
    tick();
    pin(1, 1, 0, "up1");

    // saturate at MAX=9, tc on every limit step
    load = 1'b1;
    lv   = 8'd8;
    sat  = 1'b1;
    tick();
    pin(1, 8, 0, "load8");
    load = 1'b0;
    tick();
    pin(1, 9, 0, "sat_reach");
    for (int k = 0; k < 3; k++) begin
      tick();
      pin(1, 9, 1, "sat_hold");
    end
    up = 1'b0;
    tick();
    pin(1, 8, 0, "sat_down");

    // prescaler with an en gap
    load = 1'b1;
    lv   = 8'd0;
    en   = 1'b0;
    sat  = 1'b0;
    up   = 1'b1;
    tick();
    pin(2, 0, 0, "pre_load");
    load = 1'b0;
    en   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      pin(2, 0, 0, "pre_run");
    end
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      pin(2, 0, 0, "pre_gap");
    end
    en = 1'b1;
    tick();
    pin(2, 1, 0, "pre_step1");
    for (int k = 0; k < 3; k++) begin
      tick();
      pin(2, 1, 0, "pre_wait");
    end
    tick();
    pin(2, 2, 0, "pre_step2");

    // clamped load colliding with a step, MAX=99
    load = 1'b1;
    lv   = 8'd200;
    en   = 1'b1;
    up   = 1'b1;
    sat  = 1'b0;
    tick();
    pin(3, 99, 0, "clamp");
    load = 1'b0;
    tick();
    pin(3, 0, 1, "clamp_wrap");

    // asynchronous reset mid-prescale
    load = 1'b1;
    lv   = 8'd5;
    tick();
    pin(2, 5, 0, "mid_load");
    load = 1'b0;
    tick();
    pin(2, 5, 0, "mid_pc1");
    tick();
    pin(2, 5, 0, "mid_pc2");
    #2;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("async u%0d.Q", i),
            int'(qv[i]), 0);
      check($sformatf("async u%0d.tc", i),
            int'(tcv[i]), 0);
    end
    tick();
    rst = 1'b1;
    en  = 1'b1;
    up  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      pin(2, 0, 0, "post_rst");
    end
    tick();
    pin(2, 1, 0, "post_step");

    en = 1'b0;
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised up/down counter for timer, sequencer and display-scan logic. It replaces fixed 4-bit down counters with one block that has:
- configurable width and terminal value (modulus),
- runtime direction select,
- wrap or saturate mode,
- synchronous load,
- clock-enable prescaler,
- registered terminal-count pulse for cascading or interrupt generation.

## Interface
Parameters:
- WIDTH, 4, counter width in bits; legal range 1 to 32.
- MAX, 15, terminal (highest) count value; legal range 1 to 2^WIDTH-1; the count range is 0 to MAX.
- PRESCALE, 1, number of enabled cycles per count step; must be 1 or more; 1 means step on every enabled cycle.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count enable; advances the prescaler.
- up  input  1  direction; 1 = count up, 0 = count down; sampled on each step.
- sat  input  1  limit mode; 1 = saturate at the limit, 0 = wrap around.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value to load.
- Q  output  WIDTH  current count (registered).
- tc  output  1  terminal-count pulse (registered), high for one cycle.

## Operation
Internal state:
- Prescaler register `pc`, width clog2(PRESCALE), with a minimum of 1 bit.
- A step is generated in a cycle when en=1 and pc==PRESCALE-1.

Per clock edge, evaluated in priority order:
1. **Reset** (rst=0, asynchronous): Q=0, tc=0, pc=0.
2. **Load** (load=1, regardless of en):
   - Q = min(load_val, MAX).
   - pc = 0.
   - tc = 0.
3. **Hold** (en=0): Q and pc hold; tc=0.
4. **Enabled** (en=1):
   - If pc==PRESCALE-1: pc=0 and a step occurs.
   - Otherwise: pc=pc+1, Q holds, tc=0.

Step, counting up (up=1):
- Q<MAX: Q=Q+1, tc=0.
- Q==MAX: tc=1; Q=0 when sat=0, Q holds MAX when sat=1.

Step, counting down (up=0):
- Q>0: Q=Q-1, tc=0.
- Q==0: tc=1; Q=MAX when sat=0, Q holds 0 when sat=1.

Rules:
- Arithmetic is in WIDTH bits. Q is never above MAX, because loads are clamped and every step is range-checked. No modulo-2^WIDTH overflow is relied upon unless MAX=2^WIDTH-1.
- In saturate mode, tc pulses on every step attempted at the limit, not only the first one.
- A direction change takes effect on the next step. It does not reset pc.
- Toggling sat never changes Q directly. It only affects the next limit step.

## Timing
- Reset is asynchronous on assertion. Deassertion is assumed synchronised upstream. The first step can occur on the first rising edge after rst goes high.
- Step latency:
  - PRESCALE=1: Q changes on the same edge at which en=1 is sampled.
  - General case: a step occurs on every PRESCALE-th enabled edge after a reset or load.
- tc is asserted on the same edge that performs the wrap or limit step. It is high for exactly one clock cycle, unless the next cycle is also a limit step (saturate, PRESCALE=1), in which case it stays high.
- Load and step requested together: load wins; no step and no tc that cycle.
- Reset mid-prescale or mid-count: all state clears immediately. No pending step survives reset.
- en gaps freeze pc. Prescaler progress is preserved across the gap.

## Test plan
- WIDTH=4, MAX=15, PRESCALE=1, up=0, sat=0, en=1 from reset -> Q sequence 0,15,14,...,1,0,15; tc high only in the cycles where Q=15 follows Q=0.
- MAX=9, up=1, sat=0, load_val=7, load pulse, then en=1 -> Q 7,8,9,0,1; tc high for the single cycle with Q=0.
- MAX=9, sat=1, up=1 from Q=8, en=1 for 4 cycles -> Q 9,9,9,9; tc low on the first cycle, high on the next 3. Then up=0 -> Q 8 with tc=0.
- PRESCALE=4, up=1, en=1 for 3 cycles, en=0 for 5 cycles, en=1 for 5 cycles -> Q stays 0 until the 4th enabled edge, then becomes 1. The next step comes 4 enabled edges later; none occurs during the en=0 gap.
- WIDTH=8, MAX=99: load_val=200 with load=1 and en=1 in the same cycle -> Q=99, pc=0, tc=0. The next step (up=1, sat=0) gives Q=0 with tc=1.
- Counting with PRESCALE=4 at Q=5, pc=2; assert rst=0 between clock edges -> Q=0 and tc=0 immediately, without waiting for clk. After release, the first step needs 4 enabled edges.
